// File: rtl/oled_arb_pkg.sv
// Shared types and default sizing for the OLED program arbiter.
package oled_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int ADRW_DEF    = 8;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/oled_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module oled_rr_picker #(
    parameter int NREQ = 4,
    parameter int OW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_rr,
    output logic            o_valid,
    output logic [OW-1:0]   o_winner
);

    int          w_sum;
    logic [OW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest one to the pointer wins.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_sum    = 0;
        w_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = int'(i_rr) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = OW'(w_sum);
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/oled_program_arbiter.sv
// Round-robin arbiter that starts interpreter programs on behalf of NREQ requesters.
//   state | meaning
//   IDLE  | waiting for ready==1 and a request
//   ISSUE | intr high, waiting for the interpreter to drop ready (bounded by TIMEOUT)
//   BUSY  | program running, waiting for ready to return high
module oled_program_arbiter
    import oled_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int ADRW    = ADRW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ADRW-1:0]      adr,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      oled_en,
    output logic                      intr,
    output logic [ADRW-1:0]           i_adr,
    input  logic                      ready
);

    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            r_state;
    logic [OW-1:0]     r_rr;
    logic [OW-1:0]     r_owner;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_oled_en;
    logic              r_intr;
    logic [ADRW-1:0]   r_i_adr;

    logic              w_valid;
    logic [OW-1:0]     w_winner;
    logic [OW-1:0]     w_next_rr;

    oled_rr_picker #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_picker (
        .i_req    (req),
        .i_rr     (r_rr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    // Explicit wrap compare: NREQ need not be a power of two.
    assign w_next_rr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_owner   <= '0;
            r_timer   <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_oled_en <= 1'b0;
            r_intr    <= 1'b0;
            r_i_adr   <= '0;
        end else begin
            r_oled_en <= 1'b1;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ready && w_valid) begin
                        r_owner         <= w_winner;
                        r_i_adr         <= adr[int'(w_winner) * ADRW +: ADRW];
                        r_intr          <= 1'b1;
                        r_ack[w_winner] <= 1'b1;
                        r_timer         <= '0;
                        r_busy          <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!ready) begin
                        r_intr  <= 1'b0;
                        r_state <= BUSY;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_intr  <= 1'b0;
                        r_err   <= 1'b1;
                        r_rr    <= w_next_rr;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                BUSY: begin
                    if (ready) begin
                        r_done[r_owner] <= 1'b1;
                        r_rr            <= w_next_rr;
                        r_busy          <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign oled_en = r_oled_en;
    assign intr    = r_intr;
    assign i_adr   = r_i_adr;

endmodule

// File: tb/tb_oled_program_arbiter.sv
// Bench for oled_program_arbiter: interpreter model, grant scoreboard and vector table.
module tb_oled_program_arbiter;

    localparam int NREQ = 4;
    localparam int ADRW = 8;

    localparam int W_ACK   = 0;
    localparam int W_DONE  = 1;
    localparam int W_ERR   = 2;
    localparam int W_RHIGH = 3;
    localparam int W_RLOW  = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*ADRW-1:0] adr;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 busy;
    logic [1:0]           owner;
    logic                 oled_en;
    logic                 intr;
    logic [ADRW-1:0]      i_adr;
    logic                 ready;

    oled_program_arbiter #(.NREQ(NREQ), .ADRW(ADRW), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .adr     (adr),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .owner   (owner),
        .oled_en (oled_en),
        .intr    (intr),
        .i_adr   (i_adr),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] adr;
    } grant_t;

    typedef struct {
        logic [3:0] req;
        int         len;
        int         exp_owner;
    } vec_t;

    grant_t     ack_q[$];
    int         done_q[$];
    logic [7:0] adr_tab [4];
    vec_t       vecs [7];

    int n_chk  = 0;
    int n_pass = 0;
    bit exp_err = 1'b0;

    int m_len   = 3;
    bit m_stuck = 1'b0;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit cond(input int which);
        case (which)
            W_ACK:   return ack != '0;
            W_DONE:  return done != '0;
            W_ERR:   return err;
            W_RHIGH: return ready;
            default: return !ready;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cond(which) && cyc < limit);
        if (!cond(which)) chk($sformatf("wait_timeout_%0d", which), 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        ack_q.delete();
        done_q.delete();
        rst = 1'b0;
    endtask

    // Interpreter model: drops ready one cycle after seeing intr, for m_len cycles.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) ready = 1'b1;
            end else if (m_pend) begin
                m_pend = 1'b0;
                ready  = 1'b0;
                m_cnt  = m_len;
            end else if (intr && ready && !m_stuck) begin
                m_pend = 1'b1;
            end
        end
    end

    // Scoreboard monitor on ack / done / err pulses.
    initial begin
        grant_t e;
        int     d;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_vec", ack, 4'b0001 << e.idx);
                    chk("ack_owner", owner, e.idx);
                    chk("ack_iadr", i_adr, e.adr);
                    chk("ack_intr", intr, 1);
                    chk("ack_busy", busy, 1);
                    done_q.push_back(e.idx);
                end
            end
            if (!rst && done != '0) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_vec", done, 4'b0001 << d);
                end
                chk("done_intr", intr, 0);
                chk("done_busy", busy, 0);
            end
            if (!rst && err) begin
                chk("err_expected", exp_err, 1);
                chk("err_no_done", done, 0);
                chk("err_intr", intr, 0);
                if (done_q.size() > 0) d = done_q.pop_front();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;
        int nlow;

        adr_tab = '{8'h20, 8'h41, 8'h62, 8'h83};
        adr     = {8'h83, 8'h62, 8'h41, 8'h20};
        // Expected owners follow the rr pointer from 0 after reset.
        vecs[0] = '{4'b0001, 3, 0};
        vecs[1] = '{4'b0101, 3, 2};
        vecs[2] = '{4'b0011, 3, 0};
        vecs[3] = '{4'b1001, 3, 3};
        vecs[4] = '{4'b0110, 3, 1};
        vecs[5] = '{4'b0010, 1, 1};
        vecs[6] = '{4'b1100, 3, 2};

        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst_oled_en", oled_en, 0);
        chk("rst_intr", intr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oled_en", oled_en, 1);
        chk("post_rst_ack", ack, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_owner", owner, 0);
        chk("post_rst_intr", intr, 0);
        chk("post_rst_iadr", i_adr, 0);
        @(negedge clk);
        chk("idle_oled_en", oled_en, 1);
        chk("idle_intr", intr, 0);

        // Single request, 10-cycle program.
        m_len = 10;
        req = 4'b0001;
        ack_q.push_back('{0, adr_tab[0]});
        wait_sig(W_ACK, 5, cyc);
        chk("t2_ack_lat", cyc, 1);
        req = '0;
        chk("t2_iadr", i_adr, 8'h20);
        wait_sig(W_RLOW, 5, cyc);
        chk("t2_intr_held", intr, 1);
        chk("t2_busy_issue", busy, 1);
        @(negedge clk);
        chk("t2_intr_clear", intr, 0);
        chk("t2_busy_run", busy, 1);
        wait_sig(W_RHIGH, 30, cyc);
        chk("t2_no_early_done", done, 0);
        chk("t2_busy_until", busy, 1);
        wait_sig(W_DONE, 5, cyc);
        chk("t2_done_lat", cyc, 1);
        @(negedge clk);
        chk("t2_busy_end", busy, 0);

        // Table of arbitration vectors.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            m_len = vecs[k].len;
            req   = vecs[k].req;
            ack_q.push_back('{vecs[k].exp_owner, adr_tab[vecs[k].exp_owner]});
            wait_sig(W_ACK, 5, cyc);
            chk($sformatf("vec%0d_ack_lat", k), cyc, 1);
            req = '0;
            wait_sig(W_DONE, 40, cyc);
            @(negedge clk);
        end

        // All requesters held: order 0,1,2,3,0.
        do_reset();
        m_len = 5;
        for (int k = 0; k < 5; k++) ack_q.push_back('{k % 4, adr_tab[k % 4]});
        req = 4'b1111;
        n_done = 0;
        for (int c = 0; c < 300 && n_done < 5; c++) begin
            @(negedge clk);
            if (done != '0) n_done++;
        end
        req = '0;
        chk("rr_done_count", n_done, 5);
        repeat (3) @(negedge clk);
        chk("rr_ack_q_empty", ack_q.size(), 0);

        // Interpreter never drops ready: timeout, then the next requester runs.
        m_stuck = 1'b1;
        exp_err = 1'b1;
        m_len   = 3;
        req     = 4'b0110;
        ack_q.push_back('{1, adr_tab[1]});
        ack_q.push_back('{2, adr_tab[2]});
        wait_sig(W_ACK, 5, cyc);
        chk("to_ack_lat", cyc, 1);
        req = 4'b0100;
        wait_sig(W_ERR, 40, cyc);
        chk("to_len", cyc, 16);
        m_stuck = 1'b0;
        wait_sig(W_ACK, 5, cyc);
        chk("to_next_ack_lat", cyc, 1);
        exp_err = 1'b0;
        req = '0;
        wait_sig(W_DONE, 30, cyc);
        @(negedge clk);

        // Reset while BUSY, then no issue until ready returns.
        m_len = 20;
        req   = 4'b1000;
        ack_q.push_back('{3, adr_tab[3]});
        wait_sig(W_ACK, 5, cyc);
        req = '0;
        wait_sig(W_RLOW, 5, cyc);
        @(negedge clk);
        chk("rb_busy_before", busy, 1);
        m_len = 3;
        rst = 1'b1;
        @(negedge clk);
        chk("rb_intr", intr, 0);
        chk("rb_busy", busy, 0);
        rst = 1'b0;
        ack_q.delete();
        done_q.delete();
        req = 4'b0001;
        ack_q.push_back('{0, adr_tab[0]});
        nlow = 0;
        while (!ready && nlow < 40) begin
            @(negedge clk);
            nlow++;
            if (!ready) begin
                chk("rb_no_issue_intr", intr, 0);
                chk("rb_no_issue_ack", ack, 0);
            end
        end
        wait_sig(W_ACK, 5, cyc);
        chk("rb_resume_lat", cyc, 1);
        req = '0;
        wait_sig(W_DONE, 30, cyc);

        repeat (3) @(negedge clk);
        chk("sb_ack_empty", ack_q.size(), 0);
        chk("sb_done_empty", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
